mem_bus_arb: RTL

- Two-port arbiter that sits directly downstream of the data LSU and the instruction fetch unit.
- Merges both request streams onto the single memory port with the same valid/ready request and rvalid response protocol.
- Tracks up to Depth accepted-but-unanswered requests in an in-order owner-tag FIFO and routes each response back to the issuing port.
- The memory returns exactly one rvalid per accepted request, loads and stores alike, in acceptance order.

---
 rtl/mem_bus_arb.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mem_bus_arb.sv
// mem_bus_arb
//   Merges the instruction-fetch (IFU) and data (LSU) request streams onto a
//   single valid/ready memory port. Each accepted request pushes its owner tag
//   into an in-order FIFO of up to Depth entries. Each memory rvalid pops that
//   FIFO and is routed back to the issuing port.
//
// Ports
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   ifu_valid_i/ready_o/addr_i     fetch request
//   ifu_rdata_o/rvalid_o           fetch response
//   lsu_valid_i/ready_o/addr_i     LSU request
//   lsu_wdata_i/wmask_i            LSU store data / byte mask (mask 0 = load)
//   lsu_rdata_o/rvalid_o           LSU response
//   mem_valid_o/ready_i            memory request handshake
//   mem_addr_o/wdata_o/wmask_o     memory request payload
//   mem_rdata_i/rvalid_i           memory response
//   outstanding_o                  accepted-but-unanswered request count
module mem_bus_arb #(
  parameter int unsigned Xlen     = 64,
  parameter int unsigned MaskBits = Xlen / 8,
  parameter int unsigned Depth    = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         ifu_valid_i,
  output logic                         ifu_ready_o,
  input  logic [Xlen-1:0]              ifu_addr_i,
  output logic [Xlen-1:0]              ifu_rdata_o,
  output logic                         ifu_rvalid_o,
  input  logic                         lsu_valid_i,
  output logic                         lsu_ready_o,
  input  logic [Xlen-1:0]              lsu_addr_i,
  input  logic [Xlen-1:0]              lsu_wdata_i,
  input  logic [MaskBits-1:0]          lsu_wmask_i,
  output logic [Xlen-1:0]              lsu_rdata_o,
  output logic                         lsu_rvalid_o,
  output logic                         mem_valid_o,
  input  logic                         mem_ready_i,
  output logic [Xlen-1:0]              mem_addr_o,
  output logic [Xlen-1:0]              mem_wdata_o,
  output logic [MaskBits-1:0]          mem_wmask_o,
  input  logic [Xlen-1:0]              mem_rdata_i,
  input  logic                         mem_rvalid_i,
  output logic [$clog2(Depth+1)-1:0]   outstanding_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [CntW-1:0]  count_q, count_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [Depth-1:0] tag_q;             // 1 = LSU owns the entry, 0 = IFU
  logic             lock_q, lock_d;
  logic             lock_lsu_q, lock_lsu_d;
  logic             prio_lsu_q, prio_lsu_d;

  logic grant_lsu;
  logic req_valid;
  logic full;
  logic push;
  logic pop;
  logic head_lsu;
  logic both_valid;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(Depth - 1)) begin
      return '0;
    end
    return p + PtrW'(1);
  endfunction

  // Grant selection: a locked request wins outright. Otherwise a lone
  // requester wins, and a tie goes to the port named by prio.
  always_comb begin
    grant_lsu = prio_lsu_q;
    if (lock_q) begin
      grant_lsu = lock_lsu_q;
    end else if (lsu_valid_i && !ifu_valid_i) begin
      grant_lsu = 1'b1;
    end else if (ifu_valid_i && !lsu_valid_i) begin
      grant_lsu = 1'b0;
    end
  end

  assign both_valid = ifu_valid_i && lsu_valid_i;
  assign full       = (count_q == CntW'(Depth));
  assign req_valid  = grant_lsu ? lsu_valid_i : ifu_valid_i;

  // A full FIFO blocks issue even if it is popped in the same cycle.
  // This avoids a combinational path from mem_rvalid_i to mem_valid_o.
  assign mem_valid_o = req_valid && !full;
  assign push        = mem_valid_o && mem_ready_i;
  assign pop         = mem_rvalid_i && (count_q != '0);
  assign head_lsu    = tag_q[rd_ptr_q];

  assign mem_addr_o  = grant_lsu ? lsu_addr_i  : ifu_addr_i;
  assign mem_wdata_o = grant_lsu ? lsu_wdata_i : '0;
  assign mem_wmask_o = grant_lsu ? lsu_wmask_i : '0;

  assign ifu_ready_o = push && !grant_lsu;
  assign lsu_ready_o = push &&  grant_lsu;

  assign ifu_rvalid_o  = pop && !head_lsu;
  assign lsu_rvalid_o  = pop &&  head_lsu;
  assign ifu_rdata_o   = mem_rdata_i;
  assign lsu_rdata_o   = mem_rdata_i;
  assign outstanding_o = count_q;

  always_comb begin
    lock_d     = lock_q;
    lock_lsu_d = lock_lsu_q;
    prio_lsu_d = prio_lsu_q;
    count_d    = count_q + CntW'(push) - CntW'(pop);
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    if (push) begin
      lock_d = 1'b0;
      // Only a contested grant hands priority to the other port.
      if (both_valid) begin
        prio_lsu_d = !grant_lsu;
      end
    end else if (mem_valid_o) begin
      // Freeze the presented request until the memory takes it.
      lock_d     = 1'b1;
      lock_lsu_d = grant_lsu;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tag_q      <= '0;
      lock_q     <= 1'b0;
      lock_lsu_q <= 1'b0;
      prio_lsu_q <= 1'b1;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      lock_q     <= lock_d;
      lock_lsu_q <= lock_lsu_d;
      prio_lsu_q <= prio_lsu_d;
      if (push) begin
        tag_q[wr_ptr_q] <= grant_lsu;
      end
    end
  end

`ifndef SYNTHESIS
  // A response with nothing outstanding is dropped. The check flags it.
  spurious_rvalid_a : assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(mem_rvalid_i && (count_q == '0)))
    else $warning("mem_bus_arb: spurious mem_rvalid_i dropped (no outstanding request)");
`endif

endmodule
